alu_rr_arbiter: RTL and testbench

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

---
 rtl/alu_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Two-requester front end for a shared 4-bit ALU: picks one requester, latches its operands,
// executes in one cycle, and returns a registered result with a one-cycle done pulse.
`timescale 1ns/1ps

module alu_rr_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] result,
    output logic       carry_out,
    output logic       zero,
    output logic       busy,
    output logic [7:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] op_q;
    logic       id_q;
    logic       last_grant;

    logic       any_req;
    logic       winner;
    logic [4:0] alu_temp;
    logic       alu_carry;

    // last_grant resets to 1 so requester 0 takes the first simultaneous request.
    always_comb begin
        any_req = req0 | req1;
        winner  = 1'b0;
        if (FAIR) begin
            if (req0 && req1) begin
                winner = ~last_grant;
            end else begin
                winner = req1;
            end
        end else begin
            winner = ~req0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requests are only looked at in IDLE; the capture also moves the fairness pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= 4'd0;
            b_q        <= 4'd0;
            op_q       <= 3'd0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            a_q        <= winner ? a1  : a0;
            b_q        <= winner ? b1  : b0;
            op_q       <= winner ? op1 : op0;
            id_q       <= winner;
            last_grant <= winner;
        end
    end

    always_comb begin
        alu_temp = 5'd0;
        case (op_q)
            3'b000:  alu_temp = {1'b0, a_q} + {1'b0, b_q};
            3'b001:  alu_temp = {1'b0, a_q} - {1'b0, b_q};
            3'b010:  alu_temp = {1'b0, a_q & b_q};
            3'b011:  alu_temp = {1'b0, a_q | b_q};
            3'b100:  alu_temp = {1'b0, a_q ^ b_q};
            3'b101:  alu_temp = {1'b0, b_q[2:0], 1'b0};
            3'b110:  alu_temp = {2'b00, b_q[3:1]};
            default: alu_temp = {1'b0, b_q};
        endcase
        alu_carry = (op_q[2:1] == 2'b00) ? alu_temp[4] : 1'b0;
    end

    // Results only change when an EXEC cycle completes, so they hold between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= 4'd0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else if (state == EXEC) begin
            result    <= alu_temp[3:0];
            carry_out <= alu_carry;
            zero      <= (alu_temp[3:0] == 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= 8'd0;
        end else if (state == RESP) begin
            ops_done <= ops_done + 8'd1;
        end
    end

    always_comb begin
        gnt0  = (state == EXEC) && !id_q;
        gnt1  = (state == EXEC) &&  id_q;
        done0 = (state == RESP) && !id_q;
        done1 = (state == RESP) &&  id_q;
        busy  = (state != IDLE);
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: one round-robin instance and one fixed-priority
// instance share the same stimulus, with hand-computed expectations per scenario.
`timescale 1ns/1ps

module tb_alu_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;

    logic       f_gnt0, f_gnt1, f_done0, f_done1, f_carry, f_zero, f_busy;
    logic [3:0] f_result;
    logic [7:0] f_ops;
    logic       x_gnt0, x_gnt1, x_done0, x_done1, x_carry, x_zero, x_busy;
    logic [3:0] x_result;
    logic [7:0] x_ops;

    int n_cmp;
    int n_fail;

    alu_rr_arbiter #(.FAIR(1'b1)) dut_fair (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
        .result(f_result), .carry_out(f_carry), .zero(f_zero),
        .busy(f_busy), .ops_done(f_ops)
    );

    alu_rr_arbiter #(.FAIR(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .gnt0(x_gnt0), .gnt1(x_gnt1), .done0(x_done0), .done1(x_done1),
        .result(x_result), .carry_out(x_carry), .zero(x_zero),
        .busy(x_busy), .ops_done(x_ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0; op0 = 3'd0; op1 = 3'd0;
        apply_reset();
        n_cmp++;
        if ({f_gnt0, f_gnt1, f_done0, f_done1, f_carry, f_zero, f_busy} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags_fair: got %b expected 0000000",
                     {f_gnt0, f_gnt1, f_done0, f_done1, f_carry, f_zero, f_busy});
        end
        n_cmp++;
        if (f_result !== 4'd0 || f_ops !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_values_fair: result=%0d ops_done=%0d expected 0/0", f_result, f_ops);
        end
        n_cmp++;
        if ({x_gnt0, x_gnt1, x_done0, x_done1, x_carry, x_zero, x_busy, x_result, x_ops} !== 19'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_fixed: got %h expected 0",
                     {x_gnt0, x_gnt1, x_done0, x_done1, x_carry, x_zero, x_busy, x_result, x_ops});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (f_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle_busy: got %b expected 0", f_busy);
        end
    endtask

    // Table of single-requester operations: id, a, b, op, expected result / carry / zero.
    task automatic test_alu_ops();
        logic       t_id [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] t_a  [13] = '{4'd9, 4'd3, 4'd8, 4'd2, 4'd10, 4'd10, 4'd10, 4'd10, 4'd0, 4'd10, 4'd10, 4'd5, 4'd7};
        logic [3:0] t_b  [13] = '{4'd8, 4'd5, 4'd8, 4'd3, 4'd6, 4'd6, 4'd6, 4'd6, 4'd15, 4'd6, 4'd6, 4'd0, 4'd7};
        logic [2:0] t_op [13] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd1};
        logic [3:0] t_r  [13] = '{4'd1, 4'd14, 4'd0, 4'd15, 4'd4, 4'd2, 4'd14, 4'd12, 4'd14, 4'd3, 4'd6, 4'd0, 4'd0};
        logic       t_c  [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       t_z  [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 13; i++) begin
            if (t_id[i]) begin
                req1 = 1'b1; a1 = t_a[i]; b1 = t_b[i]; op1 = t_op[i];
                a0 = 4'hF; b0 = 4'hF; op0 = 3'd3;
            end else begin
                req0 = 1'b1; a0 = t_a[i]; b0 = t_b[i]; op0 = t_op[i];
                a1 = 4'hF; b1 = 4'hF; op1 = 3'd3;
            end
            tick();
            n_cmp++;
            if ({f_gnt0, f_gnt1} !== (t_id[i] ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("[TB] FAIL op%0d_gnt: got %b expected %b", i, {f_gnt0, f_gnt1},
                         t_id[i] ? 2'b01 : 2'b10);
            end
            req0 = 1'b0; req1 = 1'b0;
            a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
            tick();
            n_cmp++;
            if ({f_done0, f_done1} !== (t_id[i] ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("[TB] FAIL op%0d_done: got %b expected %b", i, {f_done0, f_done1},
                         t_id[i] ? 2'b01 : 2'b10);
            end
            n_cmp++;
            if ({f_result, f_carry, f_zero} !== {t_r[i], t_c[i], t_z[i]}) begin
                n_fail++;
                $display("[TB] FAIL op%0d_result: got r=%0d c=%b z=%b expected r=%0d c=%b z=%b",
                         i, f_result, f_carry, f_zero, t_r[i], t_c[i], t_z[i]);
            end
            n_cmp++;
            if ({x_result, x_carry, x_zero} !== {t_r[i], t_c[i], t_z[i]}) begin
                n_fail++;
                $display("[TB] FAIL op%0d_result_fixed: got r=%0d c=%b z=%b expected r=%0d c=%b z=%b",
                         i, x_result, x_carry, x_zero, t_r[i], t_c[i], t_z[i]);
            end
            tick();
            n_cmp++;
            if (f_ops !== 8'(i + 1) || f_busy !== 1'b0 || {f_done0, f_done1} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL op%0d_complete: ops_done=%0d busy=%b done=%b expected %0d/0/00",
                         i, f_ops, f_busy, {f_done0, f_done1}, i + 1);
            end
        end
    endtask

    task automatic test_hold();
        a0 = 4'd3; b0 = 4'd1; op0 = 3'd0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if ({f_result, f_carry, f_zero, f_busy} !== {4'd0, 1'b0, 1'b1, 1'b0} || f_ops !== 8'd13) begin
            n_fail++;
            $display("[TB] FAIL hold: got r=%0d c=%b z=%b busy=%b ops=%0d expected r=0 c=0 z=1 busy=0 ops=13",
                     f_result, f_carry, f_zero, f_busy, f_ops);
        end
    endtask

    // Both requesters held: fair instance alternates every 3 cycles, fixed instance serves 0 only.
    task automatic test_contention();
        logic [1:0] exp_fg, exp_fd, exp_xg, exp_xd;
        logic [3:0] exp_r;
        apply_reset();
        a0 = 4'd1; b0 = 4'd1; op0 = 3'd0;
        a1 = 4'd2; b1 = 4'd2; op1 = 3'd0;
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_fg = (k % 6 == 0) ? 2'b10 : (k % 6 == 3) ? 2'b01 : 2'b00;
            exp_fd = (k % 6 == 1) ? 2'b10 : (k % 6 == 4) ? 2'b01 : 2'b00;
            exp_xg = (k % 3 == 0) ? 2'b10 : 2'b00;
            exp_xd = (k % 3 == 1) ? 2'b10 : 2'b00;
            n_cmp++;
            if ({f_gnt0, f_gnt1, f_done0, f_done1} !== {exp_fg, exp_fd}) begin
                n_fail++;
                $display("[TB] FAIL fair_k%0d: gnt=%b done=%b expected gnt=%b done=%b",
                         k, {f_gnt0, f_gnt1}, {f_done0, f_done1}, exp_fg, exp_fd);
            end
            n_cmp++;
            if ({x_gnt0, x_gnt1, x_done0, x_done1} !== {exp_xg, exp_xd}) begin
                n_fail++;
                $display("[TB] FAIL fixed_k%0d: gnt=%b done=%b expected gnt=%b done=%b",
                         k, {x_gnt0, x_gnt1}, {x_done0, x_done1}, exp_xg, exp_xd);
            end
            if (k % 3 == 1) begin
                exp_r = (k % 6 == 1) ? 4'd2 : 4'd4;
                n_cmp++;
                if (f_result !== exp_r) begin
                    n_fail++;
                    $display("[TB] FAIL fair_result_k%0d: got %0d expected %0d", k, f_result, exp_r);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_cmp++;
        if (f_ops !== 8'd4 || x_ops !== 8'd4) begin
            n_fail++;
            $display("[TB] FAIL contention_ops: fair=%0d fixed=%0d expected 4/4", f_ops, x_ops);
        end
    endtask

    task automatic test_abort();
        req1 = 1'b1; a1 = 4'd3; b1 = 4'd5; op1 = 3'd1;
        tick();
        n_cmp++;
        if ({f_gnt0, f_gnt1} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL abort_gnt1: got %b expected 01", {f_gnt0, f_gnt1});
        end
        rst_n = 1'b0;
        req1 = 1'b0;
        #1;
        n_cmp++;
        if ({f_gnt0, f_gnt1, f_done0, f_done1, f_carry, f_zero, f_busy, f_result, f_ops} !== 19'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_async_clear: got %h expected 0",
                     {f_gnt0, f_gnt1, f_done0, f_done1, f_carry, f_zero, f_busy, f_result, f_ops});
        end
        tick();
        n_cmp++;
        if ({f_done0, f_done1, f_busy} !== 3'b000 || f_ops !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_done: done=%b busy=%b ops=%0d expected 00/0/0",
                     {f_done0, f_done1}, f_busy, f_ops);
        end
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 4'd9; b0 = 4'd8; op0 = 3'd0;
        tick();
        n_cmp++;
        if ({f_gnt0, f_gnt1} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL abort_next_gnt: got %b expected 10", {f_gnt0, f_gnt1});
        end
        req0 = 1'b0;
        tick();
        n_cmp++;
        if ({f_done0, f_result, f_carry, f_zero} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL abort_next_done: done0=%b r=%0d c=%b z=%b expected 1/1/1/0",
                     f_done0, f_result, f_carry, f_zero);
        end
        tick();
        n_cmp++;
        if (f_ops !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL abort_next_ops: got %0d expected 1", f_ops);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd7; op0 = 3'd4;
        for (int k = 0; k < 768; k++) begin
            tick();
            if (k % 3 == 1) begin
                n_cmp++;
                if ({f_done0, f_result, f_carry, f_zero} !== {1'b1, 4'd0, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_k%0d: done0=%b r=%0d c=%b z=%b expected 1/0/0/1",
                             k, f_done0, f_result, f_carry, f_zero);
                end
            end
            if (k == 764) begin
                n_cmp++;
                if (f_ops !== 8'd255) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_ops_255: got %0d expected 255", f_ops);
                end
            end
        end
        req0 = 1'b0;
        n_cmp++;
        if (f_ops !== 8'd0 || f_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_wrap: ops=%0d busy=%b expected 0/0", f_ops, f_busy);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req0   = 1'b0;
        req1   = 1'b0;
        test_reset();
        test_alu_ops();
        test_hold();
        test_contention();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
